// File: rtl/rsa_stream_frontend.sv
// Byte-serial front end for the 256-bit RSA core: assembles N, d and ciphertext blocks, launches the core, serializes the plaintext.
// Build option: RSA_FULL_WIDTH_OUT_EN sends all 32 result bytes; otherwise the top byte is dropped and 31 bytes are sent.
module rsa_stream_frontend (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_data,
  output logic         o_rx_ready,
  input  logic         i_rekey,
  output logic         o_tx_valid,
  output logic [7:0]   o_tx_data,
  input  logic         i_tx_ready,
  output logic [255:0] o_core_n,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_a,
  output logic         o_core_start,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);

  localparam logic [2:0] S_GET_N = 3'd0;
  localparam logic [2:0] S_GET_D = 3'd1;
  localparam logic [2:0] S_GET_A = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;

  localparam logic [5:0] RX_LAST = 6'd31;

`ifdef RSA_FULL_WIDTH_OUT_EN
  localparam int         RES_W   = 256;
  localparam logic [5:0] TX_LAST = 6'd31;
`else
  localparam int         RES_W   = 248;
  localparam logic [5:0] TX_LAST = 6'd30;
`endif

  logic [2:0]       state;
  logic [5:0]       cnt;
  logic [255:0]     n_reg;
  logic [255:0]     d_reg;
  logic [255:0]     a_reg;
  logic [RES_W-1:0] result;
  logic             rekey_take;
  logic             rx_fire;

`ifndef RSA_FULL_WIDTH_OUT_EN
  // Plaintext < N < 2^248 on this link, so the core's top byte is never sent.
  logic unused_top;
  assign unused_top = ^i_core_result[255:248];
`endif

  // Rekey is only honoured between blocks and wins over a byte offered in the same cycle.
  assign rekey_take = (state == S_GET_A) && (cnt == 6'd0) && i_rekey;
  assign rx_fire    = i_rx_valid && o_rx_ready;

  always_comb begin
    o_rx_ready = 1'b0;
    case (state)
      S_GET_N, S_GET_D: o_rx_ready = 1'b1;
      S_GET_A:          o_rx_ready = !rekey_take;
      default:          o_rx_ready = 1'b0;
    endcase
  end

  assign o_tx_valid   = (state == S_SEND);
  assign o_core_start = (state == S_START);
  assign o_tx_data    = result[RES_W-1 -: 8];
  assign o_core_n     = n_reg;
  assign o_core_d     = d_reg;
  assign o_core_a     = a_reg;

  // NOTE: all state below uses non-blocking assignment so every branch sees pre-edge values;
  // the wide operand registers are reset too because the outputs must read zero after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_GET_N;
      cnt    <= '0;
      n_reg  <= '0;
      d_reg  <= '0;
      a_reg  <= '0;
      result <= '0;
    end else begin
      case (state)
        S_GET_N: if (rx_fire) begin
          n_reg <= {n_reg[247:0], i_rx_data};
          if (cnt == RX_LAST) begin
            state <= S_GET_D;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_GET_D: if (rx_fire) begin
          d_reg <= {d_reg[247:0], i_rx_data};
          if (cnt == RX_LAST) begin
            state <= S_GET_A;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_GET_A: begin
          if (rekey_take) begin
            state <= S_GET_N;
            cnt   <= '0;
          end else if (rx_fire) begin
            a_reg <= {a_reg[247:0], i_rx_data};
            if (cnt == RX_LAST) begin
              state <= S_START;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: if (i_core_finished) begin
          result <= i_core_result[RES_W-1:0];
          state  <= S_SEND;
        end
        S_SEND: if (i_tx_ready) begin
          result <= {result[RES_W-9:0], 8'h00};
          if (cnt == TX_LAST) begin
            state <= S_GET_A;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state <= S_GET_N;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_stream_frontend.sv
// Self-checking bench for rsa_stream_frontend: a behavioural core model plus a tx scoreboard fed when ciphertext is driven.
module tb_rsa_stream_frontend;

`ifdef RSA_FULL_WIDTH_OUT_EN
  localparam int NB = 32;
`else
  localparam int NB = 31;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_rx_valid;
  logic [7:0]   i_rx_data;
  logic         o_rx_ready;
  logic         i_rekey;
  logic         o_tx_valid;
  logic [7:0]   o_tx_data;
  logic         i_tx_ready;
  logic [255:0] o_core_n, o_core_d, o_core_a;
  logic         o_core_start;
  logic [255:0] i_core_result;
  logic         i_core_finished;

  rsa_stream_frontend dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
    .i_rekey(i_rekey),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_core_n(o_core_n), .o_core_d(o_core_d), .o_core_a(o_core_a),
    .o_core_start(o_core_start), .i_core_result(i_core_result),
    .i_core_finished(i_core_finished)
  );

  always #5 i_clk = ~i_clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   exp_q[$];
  bit           core_auto = 1'b1;
  bit           tx_toggle = 1'b0;
  int           start_cnt = 0;
  logic [255:0] cap_n, cap_d, cap_a;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mod_pow(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] m);
    longint unsigned r, x, mm;
    mm = m[63:0];
    if (mm == 0) return '0;
    r = 1;
    x = b[63:0] % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return {192'b0, r};
  endfunction

  // Behavioural core: captures operands on start, answers a few cycles later.
  initial begin
    i_core_finished = 1'b0;
    i_core_result   = '0;
    forever begin
      @(negedge i_clk);
      if (o_core_start) begin
        start_cnt++;
        cap_n = o_core_n;
        cap_d = o_core_d;
        cap_a = o_core_a;
        if (core_auto) begin
          repeat (3) @(negedge i_clk);
          check("core_a_held", o_core_a, cap_a);
          i_core_result   = mod_pow(cap_a, cap_d, cap_n);
          i_core_finished = 1'b1;
          @(negedge i_clk);
          check("tx_valid_at_f1", o_tx_valid, 1);
          i_core_finished = 1'b0;
        end
      end
    end
  end

  // Tx sink: chooses ready each cycle, pops the scoreboard on every transfer.
  initial begin
    bit         r;
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    i_tx_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        i_tx_ready = 1'b0;
        hold_v     = 1'b0;
      end else begin
        if (tx_toggle && hold_v) begin
          check("tx_hold_valid", o_tx_valid, 1);
          check("tx_hold_data", o_tx_data, hold_d);
        end
        r          = tx_toggle ? !i_tx_ready : 1'b1;
        i_tx_ready = r;
        hold_v     = o_tx_valid && !r;
        hold_d     = o_tx_data;
        if (o_tx_valid && r) begin
          if (exp_q.size() == 0) check("tx_unexpected_byte", o_tx_valid, 0);
          else check("tx_byte", o_tx_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    #1;
    while (!o_rx_ready && t < 100) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    if (t >= 100) check("rx_ready_timeout", o_rx_ready, 1);
    @(negedge i_clk);
  endtask

  task automatic send_word(input logic [255:0] w);
    for (int i = 31; i >= 0; i--) send_byte(w[i*8 +: 8]);
    i_rx_valid = 1'b0;
  endtask

  task automatic load_key(input logic [255:0] n, input logic [255:0] d);
    send_word(n);
    send_word(d);
  endtask

  // Pushes the expected plaintext bytes, streams the ciphertext and waits for the drain.
  task automatic run_block(input logic [255:0] a, input logic [255:0] n, input logic [255:0] d);
    logic [255:0] res;
    int           starts0;
    int           t;
    res = mod_pow(a, d, n);
    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(res[i*8 +: 8]);
    starts0 = start_cnt;
    send_word(a);
    check("start_at_k1", o_core_start, 1);
    @(negedge i_clk);
    check("start_one_cycle", o_core_start, 0);
    t = 0;
    while ((exp_q.size() != 0 || o_tx_valid) && t < 3000) begin
      @(negedge i_clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    check("start_count", start_cnt - starts0, 1);
    check("core_n", cap_n, n);
    check("core_d", cap_d, d);
    check("core_a", cap_a, a);
    check("rx_ready_after_send", o_rx_ready, 1);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
    i_rekey    = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_rx_ready", o_rx_ready, 1);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_core_start", o_core_start, 0);
    check("rst_core_n", o_core_n, 0);
    check("rst_core_d", o_core_d, 0);
    check("rst_core_a", o_core_a, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Key load and decrypt: 2^23 mod 187 = 162 (0xA2).
    load_key(256'd187, 256'd23);
    run_block(256'd2, 256'd187, 256'd23);

    // Second block, same key: 5^23 mod 187 = 180 (0xB4).
    run_block(256'd5, 256'd187, 256'd23);
    check("key_n_persist", o_core_n, 256'd187);
    check("key_d_persist", o_core_d, 256'd23);

    // Rekey takes priority over a byte offered at the block boundary.
    i_rekey    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hFF;
    #1;
    check("rekey_rx_ready", o_rx_ready, 0);
    @(negedge i_clk);
    i_rekey    = 1'b0;
    i_rx_valid = 1'b0;
    check("rekey_no_byte", o_core_a, 256'd5);
    // New key: 3^7 mod 143 = 42 (0x2A).
    load_key(256'd143, 256'd7);
    run_block(256'd3, 256'd143, 256'd7);

    // Backpressure with ready toggling every cycle.
    tx_toggle = 1'b1;
    run_block(256'd100, 256'd143, 256'd7);
    tx_toggle = 1'b0;

    // Reset while the core is busy; a late finish must be ignored.
    core_auto = 1'b0;
    send_word(256'd2);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst_rx_ready", o_rx_ready, 1);
    check("midrst_tx_valid", o_tx_valid, 0);
    check("midrst_core_start", o_core_start, 0);
    check("midrst_core_n", o_core_n, 0);
    check("midrst_core_a", o_core_a, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_core_result   = '1;
    i_core_finished = 1'b1;
    @(negedge i_clk);
    i_core_finished = 1'b0;
    check("late_finish_tx_valid", o_tx_valid, 0);
    check("late_finish_rx_ready", o_rx_ready, 1);
    @(negedge i_clk);
    check("late_finish_tx_valid2", o_tx_valid, 0);
    core_auto = 1'b1;
    load_key(256'd187, 256'd23);
    run_block(256'd2, 256'd187, 256'd23);

    repeat (3) @(negedge i_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
